// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports (F, D) and the shared memory port.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic [31:0] f_rdata;
    logic        f_done;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        d_done;

    logic [31:0] mem_addr;
    logic        mem_access;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  f_req, f_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
        output f_rdata, f_done, d_rdata, d_done,
               mem_addr, mem_access, mem_wdata, mem_wmask, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
        input  f_rdata, f_done, d_rdata, d_done,
               mem_addr, mem_access, mem_wdata, mem_wmask, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between fetch port F and load/store port D.
// Each transaction: grant, one-cycle strobe, MEM_LATENCY-cycle wait, one-cycle done pulse.
module mem_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic         clk,
    input  logic         resetn,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    state_t      r_state;
    logic        r_grant_d;
    logic [3:0]  r_cnt;
    logic [31:0] r_mem_addr;
    logic        r_mem_access;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;
    logic [31:0] r_f_rdata;
    logic [31:0] r_d_rdata;
    logic        r_f_done;
    logic        r_d_done;
    logic        r_busy;

    logic        w_any_req;
    logic        w_pick_d;

    assign w_any_req = bus.f_req | bus.d_req;
    // r_grant_d doubles as last_grant: on contention the other port wins.
    assign w_pick_d  = bus.d_req & (~bus.f_req | ~r_grant_d);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_grant_d    <= 1'b0;
            r_cnt        <= 4'd0;
            r_mem_addr   <= 32'd0;
            r_mem_access <= 1'b0;
            r_mem_wdata  <= 32'd0;
            r_mem_wmask  <= 4'd0;
            r_f_rdata    <= 32'd0;
            r_d_rdata    <= 32'd0;
            r_f_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state      <= ACCESS;
                        r_mem_access <= 1'b1;
                        r_busy       <= 1'b1;
                        r_grant_d    <= w_pick_d;
                        if (w_pick_d) begin
                            r_mem_addr  <= bus.d_addr;
                            r_mem_wdata <= bus.d_wdata;
                            r_mem_wmask <= bus.d_wmask;
                        end else begin
                            r_mem_addr  <= bus.f_addr;
                            r_mem_wmask <= 4'd0;
                        end
                    end
                end
                ACCESS: begin
                    r_mem_access <= 1'b0;
                    r_cnt        <= LAT_LOAD;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (r_grant_d) begin
                            r_d_rdata <= bus.mem_rdata;
                            r_d_done  <= 1'b1;
                        end else begin
                            r_f_rdata <= bus.mem_rdata;
                            r_f_done  <= 1'b1;
                        end
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_f_done <= 1'b0;
                    r_d_done <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_access = r_mem_access;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_wmask  = r_mem_wmask;
    assign bus.f_rdata    = r_f_rdata;
    assign bus.d_rdata    = r_d_rdata;
    assign bus.f_done     = r_f_done;
    assign bus.d_done     = r_d_done;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: latency-1 and latency-3 instances, a word-addressed memory model,
// a vector table of single transactions and hand-written contention/reset sequences.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if bus1 ();
    mem_arbiter_if bus3 ();

    mem_arbiter #(.MEM_LATENCY(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1.slave));
    mem_arbiter #(.MEM_LATENCY(3)) dut3 (.clk(clk), .resetn(resetn), .bus(bus3.slave));

    function automatic logic [31:0] init_word(int i);
        return 32'h1357_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Memory model: filled on the first edge, byte-masked writes from dut1 only.
    logic [31:0] mem [256];
    logic        mem_ready = 1'b0;
    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (bus1.mem_access) begin
            for (int b = 0; b < 4; b++)
                if (bus1.mem_wmask[b]) mem[bus1.mem_addr[9:2]][b*8 +: 8] <= bus1.mem_wdata[b*8 +: 8];
        end
        pipe1    <= bus1.mem_access ? mem[bus1.mem_addr[9:2]] : 32'hBAD0_0001;
        pipe3[0] <= bus3.mem_access ? mem[bus3.mem_addr[9:2]] : 32'hBAD0_0003;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign bus1.mem_rdata = pipe1;
    assign bus3.mem_rdata = pipe3[2];

    typedef struct {
        int          dut;
        bit          is_d;
        logic [31:0] data;
        bit          chk;
        int          cyc;
    } exp_t;

    exp_t sbq[$];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_done(input int dut, input logic fd, input logic dd,
                              input logic [31:0] fr, input logic [31:0] dr);
        int   idx;
        exp_t e;
        idx = -1;
        if (fd || dd) begin
            for (int i = 0; i < sbq.size(); i++)
                if (idx < 0 && sbq[i].dut == dut) idx = i;
            if (idx < 0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d_unexpected_done: f_done=%b d_done=%b at cycle %0d, none expected",
                         dut, fd, dd, cyc);
            end else begin
                e = sbq[idx];
                sbq.delete(idx);
                chk32($sformatf("dut%0d_done_port", dut), {30'd0, dd, fd}, e.is_d ? 32'd2 : 32'd1);
                chk32($sformatf("dut%0d_done_cycle", dut), 32'(cyc), 32'(e.cyc));
                if (e.chk) chk32($sformatf("dut%0d_rdata", dut), e.is_d ? dr : fr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        check_done(1, bus1.f_done, bus1.d_done, bus1.f_rdata, bus1.d_rdata);
        check_done(3, bus3.f_done, bus3.d_done, bus3.f_rdata, bus3.d_rdata);
    end

    task automatic check_rst(input string tag, input logic acc, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wmask,
                             input logic fd, input logic dd, input logic [31:0] fr,
                             input logic [31:0] dr, input logic busy);
        chk32({tag, "_mem_access"}, 32'(acc), 32'd0);
        chk32({tag, "_mem_addr"}, addr, 32'd0);
        chk32({tag, "_mem_wdata"}, wdata, 32'd0);
        chk32({tag, "_mem_wmask"}, 32'(wmask), 32'd0);
        chk32({tag, "_f_done"}, 32'(fd), 32'd0);
        chk32({tag, "_d_done"}, 32'(dd), 32'd0);
        chk32({tag, "_f_rdata"}, fr, 32'd0);
        chk32({tag, "_d_rdata"}, dr, 32'd0);
        chk32({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic idle_inputs();
        bus1.f_req = 1'b0; bus1.f_addr = 32'd0; bus1.d_req = 1'b0;
        bus1.d_addr = 32'd0; bus1.d_wdata = 32'd0; bus1.d_wmask = 4'd0;
        bus3.f_req = 1'b0; bus3.f_addr = 32'd0; bus3.d_req = 1'b0;
        bus3.d_addr = 32'd0; bus3.d_wdata = 32'd0; bus3.d_wmask = 4'd0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        sbq.delete();
    endtask

    typedef struct {
        bit          f_req;
        bit          d_req;
        logic [31:0] f_addr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_wmask;
        logic [31:0] e_addr;
        logic [3:0]  e_wmask;
        logic [31:0] e_rdata;
        bit          e_chk;
    } vec_t;

    function automatic vec_t mk(bit f, bit d, logic [31:0] fa, logic [31:0] da, logic [31:0] wd,
                                logic [3:0] wm, logic [31:0] ea, logic [3:0] ewm,
                                logic [31:0] erd, bit echk);
        vec_t v;
        v.f_req = f; v.d_req = d; v.f_addr = fa; v.d_addr = da; v.d_wdata = wd;
        v.d_wmask = wm; v.e_addr = ea; v.e_wmask = ewm; v.e_rdata = erd; v.e_chk = echk;
        return v;
    endfunction

    task automatic run_txn(input int n, input vec_t v);
        int    base;
        int    waitn;
        string tag;
        tag = $sformatf("v%0d", n);
        base = cyc;
        bus1.f_req = v.f_req; bus1.f_addr = v.f_addr;
        bus1.d_req = v.d_req; bus1.d_addr = v.d_addr;
        bus1.d_wdata = v.d_wdata; bus1.d_wmask = v.d_wmask;
        sbq.push_back('{1, v.d_req, v.e_rdata, v.e_chk, base + 3});
        waitn = 0;
        @(negedge clk);
        while (!bus1.mem_access && waitn < 8) begin
            @(negedge clk);
            waitn++;
        end
        if (!bus1.mem_access) begin
            checks++;
            errors++;
            $display("FAIL %s_access: mem_access never rose, required in cycle %0d", tag, base + 1);
        end else begin
            chk32({tag, "_access_cycle"}, 32'(cyc - base), 32'd1);
            chk32({tag, "_mem_addr"}, bus1.mem_addr, v.e_addr);
            chk32({tag, "_mem_wmask"}, 32'(bus1.mem_wmask), 32'(v.e_wmask));
            if (v.e_wmask != 4'd0) chk32({tag, "_mem_wdata"}, bus1.mem_wdata, v.d_wdata);
            chk32({tag, "_busy"}, 32'(bus1.busy), 32'd1);
        end
        waitn = 0;
        while (!(bus1.f_done || bus1.d_done) && waitn < 20) begin
            @(negedge clk);
            waitn++;
        end
        if (!(bus1.f_done || bus1.d_done)) begin
            checks++;
            errors++;
            $display("FAIL %s_done: no done pulse, required in cycle %0d", tag, base + 3);
        end
        bus1.f_req = 1'b0;
        bus1.d_req = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        logic [31:0] w16;
        logic [31:0] w16m;
        int base;

        w16  = init_word(16);
        w16m = {w16[31:16], 16'hBEEF};
        vecs[0] = mk(1, 0, 32'h10, 32'h0,  32'h0,         4'h0,    32'h10, 4'h0,    init_word(4), 1);
        vecs[1] = mk(0, 1, 32'h0,  32'h24, 32'h0,         4'h0,    32'h24, 4'h0,    init_word(9), 1);
        vecs[2] = mk(0, 1, 32'h0,  32'h40, 32'hDEADBEEF,  4'b0011, 32'h40, 4'b0011, 32'h0,        0);
        vecs[3] = mk(0, 1, 32'h0,  32'h40, 32'h0,         4'h0,    32'h40, 4'h0,    w16m,         1);
        vecs[4] = mk(1, 0, 32'h43, 32'h44, 32'hFFFFFFFF,  4'hF,    32'h43, 4'h0,    w16m,         1);
        vecs[5] = mk(0, 1, 32'h0,  32'h80, 32'h12345678,  4'hF,    32'h80, 4'hF,    32'h0,        0);
        vecs[6] = mk(1, 0, 32'h80, 32'h0,  32'h0,         4'h0,    32'h80, 4'h0,    32'h12345678, 1);

        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_rst("rst1", bus1.mem_access, bus1.mem_addr, bus1.mem_wdata, bus1.mem_wmask,
                  bus1.f_done, bus1.d_done, bus1.f_rdata, bus1.d_rdata, bus1.busy);
        check_rst("rst3", bus3.mem_access, bus3.mem_addr, bus3.mem_wdata, bus3.mem_wmask,
                  bus3.f_done, bus3.d_done, bus3.f_rdata, bus3.d_rdata, bus3.busy);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

        // Contention straight after reset: D first, then F.
        do_reset();
        base = cyc;
        bus1.f_req = 1'b1; bus1.f_addr = 32'h30;
        bus1.d_req = 1'b1; bus1.d_addr = 32'h20; bus1.d_wmask = 4'd0;
        sbq.push_back('{1, 1'b1, init_word(8), 1'b1, base + 3});
        sbq.push_back('{1, 1'b0, init_word(12), 1'b1, base + 7});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) chk32("cont_addr_d", bus1.mem_addr, 32'h20);
            if (k == 5) chk32("cont_addr_f", bus1.mem_addr, 32'h30);
            if (k == 5) chk32("cont_access_f", 32'(bus1.mem_access), 32'd1);
            if (k == 3) bus1.d_req = 1'b0;
            if (k == 7) bus1.f_req = 1'b0;
        end

        // Round-robin with both requests held.
        do_reset();
        base = cyc;
        bus1.f_req = 1'b1; bus1.f_addr = 32'h50;
        bus1.d_req = 1'b1; bus1.d_addr = 32'h60; bus1.d_wmask = 4'd0;
        sbq.push_back('{1, 1'b1, init_word(24), 1'b1, base + 3});
        sbq.push_back('{1, 1'b0, init_word(20), 1'b1, base + 7});
        sbq.push_back('{1, 1'b1, init_word(24), 1'b1, base + 11});
        sbq.push_back('{1, 1'b0, init_word(20), 1'b1, base + 15});
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk32($sformatf("rr_access_k%0d", k), 32'(bus1.mem_access), (k % 4 == 1) ? 32'd1 : 32'd0);
            if (k % 4 == 1)
                chk32($sformatf("rr_addr_k%0d", k), bus1.mem_addr, (k % 8 == 1) ? 32'h60 : 32'h50);
            if (k == 15) begin
                bus1.f_req = 1'b0;
                bus1.d_req = 1'b0;
            end
        end

        // Reset while waiting on memory: abandon, no done pulse.
        base = cyc;
        bus1.f_req = 1'b1; bus1.f_addr = 32'h10;
        @(negedge clk);
        chk32("mid_access", 32'(bus1.mem_access), 32'd1);
        @(negedge clk);
        chk32("mid_wait_busy", 32'(bus1.busy), 32'd1);
        chk32("mid_wait_access", 32'(bus1.mem_access), 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        check_rst("mid_rst", bus1.mem_access, bus1.mem_addr, bus1.mem_wdata, bus1.mem_wmask,
                  bus1.f_done, bus1.d_done, bus1.f_rdata, bus1.d_rdata, bus1.busy);
        resetn = 1'b1;
        bus1.f_req = 1'b0;
        repeat (6) @(negedge clk);
        chk32("mid_after_busy", 32'(bus1.busy), 32'd0);

        // Latency-3 instance: single fetch.
        base = cyc;
        bus3.f_req = 1'b1; bus3.f_addr = 32'h14;
        sbq.push_back('{3, 1'b0, init_word(5), 1'b1, base + 5});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk32($sformatf("lat3_access_k%0d", k), 32'(bus3.mem_access), (k == 1) ? 32'd1 : 32'd0);
            if (k == 1) chk32("lat3_addr", bus3.mem_addr, 32'h14);
            if (k == 5) bus3.f_req = 1'b0;
        end

        repeat (2) @(negedge clk);
        chk32("sb_drain", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous-read instruction/data memory between the CPU fetch port (port F) and the load/store port (port D).
- Sequences each access as issue, wait for memory latency, then return data, with round-robin arbitration when both ports request.
- Sits between the RISC-V core and the memory block. The memory block samples `mem_access` and `mem_addr` on `posedge clk`, indexes words by `mem_addr[31:2]`, and returns `mem_rdata` MEM_LATENCY cycles later.

Parameters:
- MEM_LATENCY, 1, cycles from the `mem_access` cycle to `mem_rdata` being valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  reset, synchronous, active-low.
- f_req  in  1  fetch request; held high with `f_addr` stable until `f_done`.
- f_addr  in  32  fetch byte address.
- f_rdata  out  32  fetched word; valid only while `f_done` is high.
- f_done  out  1  one-cycle completion pulse for port F.
- d_req  in  1  data request; held high with `d_addr`/`d_wdata`/`d_wmask` stable until `d_done`.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_wmask  in  4  byte write enables; 0 = load, nonzero = store.
- d_rdata  out  32  loaded word; valid only while `d_done` is high.
- d_done  out  1  one-cycle completion pulse for port D.
- mem_addr  out  32  address to memory.
- mem_access  out  1  memory strobe; high exactly one cycle per transaction.
- mem_wdata  out  32  store data to memory.
- mem_wmask  out  4  byte enables to memory; 0 for all port F accesses.
- mem_rdata  in  32  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, WAIT, DONE. All outputs are registered.
- Reset values (`resetn`=0 at posedge): state=IDLE; `mem_access`=0; `mem_addr`=0; `mem_wdata`=0; `mem_wmask`=0; `f_done`=`d_done`=0; `f_rdata`=`d_rdata`=0; `busy`=0; `last_grant`=F; latency counter=0.
- **IDLE:** samples `f_req`/`d_req` at the posedge.
  - Only one request high: grant that port.
  - Both high: grant the port opposite `last_grant`. The first contested grant after reset therefore goes to D.
  - On grant: latch `mem_addr`; latch `mem_wdata` and `mem_wmask` (D) or `mem_wmask`=0 (F); record the grant in `last_grant`; go to ACCESS.
  - Neither high: stay in IDLE.
- **ACCESS:** `mem_access`=1 for this single cycle. Load the counter with MEM_LATENCY-1, then go to WAIT.
- **WAIT:** `mem_access`=0. Decrement the counter each cycle. When the counter is 0, capture `mem_rdata` into the granted port's rdata register and go to DONE.
  - With MEM_LATENCY=1, WAIT lasts exactly one cycle.
- **DONE:** the granted port's done signal is 1 for this one cycle; the other port's done signal stays 0. Go to IDLE.
  - Requests are not sampled in DONE.
  - A req still high in the following IDLE cycle is treated as a new request.
- Latency: req sampled at edge t; `mem_access` is high in cycle t+1; done is high in cycle t+2+MEM_LATENCY.
  - MEM_LATENCY=1: 4 cycles from request to done; throughput 1 transaction per 4 cycles.
- Stores complete through the same path with identical timing. D rdata in a store's DONE cycle holds the memory's read-data value and carries no meaning; requesters ignore it.
- `mem_wmask` and `mem_wdata` hold their latched values until the next grant. `mem_addr` likewise holds.
- `f_rdata` and `d_rdata` hold their last captured value after done. They are meaningful only while done is high.
- Address bits [1:0] pass through unchanged; alignment is the requester's responsibility.
- A request dropped before done (protocol violation) does not abort the transaction; done still pulses.
- Reset in any state returns to IDLE within that edge:
  - the in-flight access is abandoned;
  - no done pulse is issued;
  - `mem_rdata` arriving afterwards is ignored.

Test Plan:
1. **Single fetch:** `f_req`=1, `f_addr`=0x10 at edge 0. Expect `mem_access`=1 with `mem_addr`=0x10 in cycle 1, and `f_done`=1 with `f_rdata`=MEM[4] in cycle 3 (MEM_LATENCY=1). Expect `d_done`=0 throughout.
2. **Contention after reset:** `f_req`=`d_req`=1, `d_wmask`=0, `d_addr`=0x20. Expect D granted first (`mem_addr`=0x20, `d_done` in cycle 3), then F (`f_done` in cycle 7).
3. **Round-robin:** both requests held high for 16 cycles. Expect grants alternating D, F, D, F, with done pulses in cycles 3, 7, 11, 15.
4. **Store:** `d_wmask`=4'b0011, `d_wdata`=0xDEADBEEF, `d_addr`=0x40. Expect `mem_wmask`=4'b0011 and `mem_wdata`=0xDEADBEEF in the `mem_access` cycle, and `d_done` in cycle 3.
5. **Reset mid-op:** `resetn`=0 during WAIT. Expect IDLE next cycle, all outputs at reset values, and no done pulse.
6. **MEM_LATENCY=3:** single fetch. Expect `mem_access` in cycle 1, `f_done` in cycle 5, and `f_rdata` equal to the memory model's delayed data.
